id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 The block SHALL have these ports; all widths derive from shared constants DATA_W=32, RF_REG_W=5.
REQ-002 iClk  in  1  single clock; all state updates on rising edge.
REQ-003 iReset_n  in  1  reset, asynchronous and active-low.
REQ-004 iInstrValid  in  1  fetch offers iInstr this cycle.
REQ-005 iInstr  in  32  MIPS instruction word.
REQ-006 oInstrReady  out  1  stage accepts iInstr this cycle.
REQ-007 oRfReg1 / oRfReg2  out  5 each  combinational rs / rt read addresses to the register file.
REQ-008 iRfData1 / iRfData2  in  32 each  register file read data for oRfReg1 / oRfReg2.
REQ-009 iWbRegWr, iWbReg, iWbData  in  1/5/32  writeback write-enable, address, data.
REQ-010 iFlush  in  1  discard the ID/EX entry (branch/jump redirect).
REQ-011 iExReady  in  1  execute stage consumes the ID/EX entry this cycle.
REQ-012 oExValid  out  1  ID/EX entry is valid.
REQ-013 oExOp, oExFunct  out  6/6  opcode and funct fields.
REQ-014 oExRsData, oExRtData, oExImm  out  32 each  operands and extended immediate.
REQ-015 oExDstReg  out  5  destination register.
REQ-016 oExRegWr, oExMemRd, oExMemWr  out  1 each  control bits.

Function
REQ-017 oRfReg1=iInstr[25:21] and oRfReg2=iInstr[20:16] at all times, independent of state.
REQ-018 Transfer into ID/EX occurs when iInstrValid & oInstrReady; the entry appears on oEx* the next cycle (latency 1).
REQ-019 oInstrReady = (~oExValid | iExReady) & ~hazard, where hazard = oExValid & oExMemRd & oExDstReg!=0 & (oExDstReg==rs | oExDstReg==rt).
REQ-020 FSM states: RUN (normal), BUBBLE (one-cycle load-use bubble), HOLD (oExValid & ~iExReady, entry frozen).
REQ-021 RUN->BUBBLE on hazard & iExReady: ID/EX loads a bubble (oExValid=0, all control bits 0); BUBBLE->RUN next cycle unconditionally.
REQ-022 RUN->HOLD when oExValid & ~iExReady; HOLD keeps every oEx* stable; HOLD->RUN when iExReady.
REQ-023 Decode: op 0x00 -> dst=rd, RegWr=1; 0x23 lw -> dst=rt, RegWr=1, MemRd=1; 0x2B sw -> MemWr=1; 0x08/0x0A -> dst=rt, RegWr=1, sign-extend; 0x0C/0x0D -> dst=rt, RegWr=1, zero-extend; 0x04 beq, 0x02 j -> no writes; any other opcode -> all control bits 0, entry still valid.
REQ-024 oExImm = sign-extended iInstr[15:0] unless zero-extend applies.
REQ-025 dst==0 forces oExRegWr=0.
REQ-026 iFlush has priority over all transfers: next cycle oExValid=0, FSM=RUN, incoming instruction in the same cycle is not accepted.

Reset
REQ-027 While iReset_n=0: oExValid=0, oExRegWr=oExMemRd=oExMemWr=0, all oEx* data fields 0, FSM=RUN; reset mid-HOLD/BUBBLE drops the entry.
REQ-028 First acceptance possible on the first rising edge after iReset_n deasserts.

Configuration
REQ-029 Macro ID_WB_BYPASS_EN: when defined, iWbRegWr & iWbReg!=0 & iWbReg==rs (resp. rt) substitutes iWbData for iRfData1 (resp. iRfData2) at ID/EX load.
REQ-030 Without ID_WB_BYPASS_EN, operands come only from iRfData1/2 and the register file alone resolves same-cycle write/read collisions.

Structure
REQ-031 DATA_W, RF_REG_W, opcode constants and a control-bundle struct SHALL live in shared package mips_pkg.
REQ-032 Combinational decode (REQ-023..025) SHALL be sub-module id_decoder; FSM and ID/EX register stay in id_stage.

Verification
REQ-033 Reset: hold iReset_n=0 with iInstrValid=1 -> oExValid=0, all outputs 0.
REQ-034 addi $2,$1,-1 (0x2022FFFF), iRfData1=5 -> next cycle oExRsData=5, oExImm=0xFFFFFFFF, oExDstReg=2, oExRegWr=1.
REQ-035 lw $3,0($1) then add $4,$3,$3 -> one cycle oInstrReady=0, one bubble (oExValid=0), add issues the following cycle.
REQ-036 iExReady=0 for 3 cycles with valid entry -> oEx* unchanged, oInstrReady=0; issue resumes the cycle iExReady=1.
REQ-037 iFlush=1 with iInstrValid=1 -> next cycle oExValid=0, instruction not accepted.
REQ-038 ID_WB_BYPASS_EN: iWbRegWr=1, iWbReg=1, iWbData=0x1234, iRfData1=0 on read of $1 -> oExRsData=0x1234; without macro -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants, opcode encodings and the decode/ID-EX bundle types.
package mips_pkg;

    localparam int DATA_W   = 32;
    localparam int RF_REG_W = 5;
    localparam int OP_W     = 6;
    localparam int IMM_W    = 16;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic regWr;
        logic memRd;
        logic memWr;
    } ctrlBundle_t;

    typedef struct packed {
        logic                valid;
        logic [OP_W-1:0]     op;
        logic [OP_W-1:0]     funct;
        logic [DATA_W-1:0]   rsData;
        logic [DATA_W-1:0]   rtData;
        logic [DATA_W-1:0]   imm;
        logic [RF_REG_W-1:0] dstReg;
        ctrlBundle_t         ctrl;
    } idEx_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } idState_e;

    function automatic logic [DATA_W-1:0] extendImm(input logic [IMM_W-1:0] imm,
                                                    input logic zeroExt);
        return zeroExt ? {{(DATA_W-IMM_W){1'b0}}, imm}
                       : {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID stage bus: fetch handshake, register-file read port, writeback snoop and ID/EX entry.
interface id_stage_if;
    import mips_pkg::*;

    logic                iInstrValid;
    logic [DATA_W-1:0]   iInstr;
    logic                oInstrReady;

    logic [RF_REG_W-1:0] oRfReg1;
    logic [RF_REG_W-1:0] oRfReg2;
    logic [DATA_W-1:0]   iRfData1;
    logic [DATA_W-1:0]   iRfData2;

    logic                iWbRegWr;
    logic [RF_REG_W-1:0] iWbReg;
    logic [DATA_W-1:0]   iWbData;

    logic                iFlush;
    logic                iExReady;

    logic                oExValid;
    logic [OP_W-1:0]     oExOp;
    logic [OP_W-1:0]     oExFunct;
    logic [DATA_W-1:0]   oExRsData;
    logic [DATA_W-1:0]   oExRtData;
    logic [DATA_W-1:0]   oExImm;
    logic [RF_REG_W-1:0] oExDstReg;
    logic                oExRegWr;
    logic                oExMemRd;
    logic                oExMemWr;

    modport slave (
        input  iInstrValid, iInstr, iRfData1, iRfData2,
        input  iWbRegWr, iWbReg, iWbData, iFlush, iExReady,
        output oInstrReady, oRfReg1, oRfReg2,
        output oExValid, oExOp, oExFunct, oExRsData, oExRtData, oExImm,
        output oExDstReg, oExRegWr, oExMemRd, oExMemWr
    );

    modport master (
        output iInstrValid, iInstr, iRfData1, iRfData2,
        output iWbRegWr, iWbReg, iWbData, iFlush, iExReady,
        input  oInstrReady, oRfReg1, oRfReg2,
        input  oExValid, oExOp, oExFunct, oExRsData, oExRtData, oExImm,
        input  oExDstReg, oExRegWr, oExMemRd, oExMemWr
    );

endinterface

// File: rtl/id_decoder.sv
// Combinational MIPS decode: control bits, destination register and extended immediate.
module id_decoder
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]     op,
    input  logic [RF_REG_W-1:0] rt,
    input  logic [RF_REG_W-1:0] rd,
    input  logic [IMM_W-1:0]    imm16,
    output ctrlBundle_t         ctrl,
    output logic [RF_REG_W-1:0] dstReg,
    output logic [DATA_W-1:0]   imm
);

    logic zeroExt;

    // Non-writing instructions report dstReg=0 so a stale rt never looks like a producer.
    always_comb begin
        ctrl    = '0;
        dstReg  = '0;
        zeroExt = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.regWr = 1'b1;
                dstReg     = rd;
            end
            OP_LW: begin
                ctrl.regWr = 1'b1;
                ctrl.memRd = 1'b1;
                dstReg     = rt;
            end
            OP_SW: begin
                ctrl.memWr = 1'b1;
            end
            OP_ADDI, OP_SLTI: begin
                ctrl.regWr = 1'b1;
                dstReg     = rt;
            end
            OP_ANDI, OP_ORI: begin
                ctrl.regWr = 1'b1;
                dstReg     = rt;
                zeroExt    = 1'b1;
            end
            default: ;
        endcase
        if (dstReg == '0)
            ctrl.regWr = 1'b0;
        imm = extendImm(imm16, zeroExt);
    end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: ID/EX register with load-use bubble, EX backpressure and flush.
// Optional ID_WB_BYPASS_EN forwards the writeback port onto the operands at load.
module id_stage
    import mips_pkg::*;
(
    input  logic    iClk,
    input  logic    iReset_n,
    id_stage_if.slave bus
);

    logic [OP_W-1:0]     op;
    logic [RF_REG_W-1:0] rs;
    logic [RF_REG_W-1:0] rt;
    logic [RF_REG_W-1:0] rd;
    logic [IMM_W-1:0]    imm16;
    logic [OP_W-1:0]     funct;

    assign op    = bus.iInstr[31:26];
    assign rs    = bus.iInstr[25:21];
    assign rt    = bus.iInstr[20:16];
    assign rd    = bus.iInstr[15:11];
    assign imm16 = bus.iInstr[15:0];
    assign funct = bus.iInstr[5:0];

    assign bus.oRfReg1 = rs;
    assign bus.oRfReg2 = rt;

    ctrlBundle_t         decCtrl;
    logic [RF_REG_W-1:0] decDst;
    logic [DATA_W-1:0]   decImm;

    id_decoder uDec (
        .op     (op),
        .rt     (rt),
        .rd     (rd),
        .imm16  (imm16),
        .ctrl   (decCtrl),
        .dstReg (decDst),
        .imm    (decImm)
    );

    logic [DATA_W-1:0] rsData;
    logic [DATA_W-1:0] rtData;

`ifdef ID_WB_BYPASS_EN
    logic wbHit1;
    logic wbHit2;
    assign wbHit1 = bus.iWbRegWr && (bus.iWbReg != '0) && (bus.iWbReg == rs);
    assign wbHit2 = bus.iWbRegWr && (bus.iWbReg != '0) && (bus.iWbReg == rt);
    assign rsData = wbHit1 ? bus.iWbData : bus.iRfData1;
    assign rtData = wbHit2 ? bus.iWbData : bus.iRfData2;
`else
    // Register file owns write/read collisions; the writeback port is not observed here.
    logic unusedWb;
    assign unusedWb = ^{bus.iWbRegWr, bus.iWbReg, bus.iWbData};
    assign rsData   = bus.iRfData1;
    assign rtData   = bus.iRfData2;
`endif

    idEx_t    exReg;
    idEx_t    exNext;
    idEx_t    exLoad;
    idState_e state;
    idState_e stateNext;
    logic     hazard;
    logic     ready;
    logic     accept;

    assign hazard = exReg.valid && exReg.ctrl.memRd && (exReg.dstReg != '0) &&
                    ((exReg.dstReg == rs) || (exReg.dstReg == rt));
    assign ready  = (!exReg.valid || bus.iExReady) && !hazard;
    assign accept = bus.iInstrValid && ready && !bus.iFlush;

    always_comb begin
        exLoad        = '0;
        exLoad.valid  = 1'b1;
        exLoad.op     = op;
        exLoad.funct  = funct;
        exLoad.rsData = rsData;
        exLoad.rtData = rtData;
        exLoad.imm    = decImm;
        exLoad.dstReg = decDst;
        exLoad.ctrl   = decCtrl;
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= RUN;
            exReg <= '0;
        end else begin
            state <= stateNext;
            exReg <= exNext;
        end
    end

    // A bubble or a consumed-but-not-refilled entry both clear the whole register.
    always_comb begin
        stateNext = state;
        exNext    = exReg;
        if (bus.iFlush) begin
            stateNext = RUN;
            exNext    = '0;
        end else begin
            if (accept)
                exNext = exLoad;
            else if (!exReg.valid || bus.iExReady)
                exNext = '0;
            case (state)
                RUN: begin
                    if (hazard && bus.iExReady)
                        stateNext = BUBBLE;
                    else if (exReg.valid && !bus.iExReady)
                        stateNext = HOLD;
                end
                BUBBLE:  stateNext = RUN;
                HOLD: begin
                    if (bus.iExReady)
                        stateNext = RUN;
                end
                default: stateNext = RUN;
            endcase
        end
    end

    assign bus.oInstrReady = ready;
    assign bus.oExValid    = exReg.valid;
    assign bus.oExOp       = exReg.op;
    assign bus.oExFunct    = exReg.funct;
    assign bus.oExRsData   = exReg.rsData;
    assign bus.oExRtData   = exReg.rtData;
    assign bus.oExImm      = exReg.imm;
    assign bus.oExDstReg   = exReg.dstReg;
    assign bus.oExRegWr    = exReg.ctrl.regWr;
    assign bus.oExMemRd    = exReg.ctrl.memRd;
    assign bus.oExMemWr    = exReg.ctrl.memWr;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: spec-level entry model checked every cycle plus literal pins.
module tb_id_stage;

    logic iClk;
    logic iReset_n;

    id_stage_if bus ();

    id_stage dut (
        .iClk     (iClk),
        .iReset_n (iReset_n),
        .bus      (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int nTests = 0;
    int nFail  = 0;

    logic [31:0] rfMem [32];
    assign bus.iRfData1 = rfMem[bus.iInstr[25:21]];
    assign bus.iRfData2 = rfMem[bus.iInstr[20:16]];

    // Expected ID/EX entry
    logic        mValid, mRegWr, mMemRd, mMemWr;
    logic [5:0]  mOp, mFunct;
    logic [31:0] mRs, mRt, mImm;
    logic [4:0]  mDst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void refDecode(input logic [31:0] ins, output logic wr, output logic rd,
                                      output logic wm, output logic [4:0] dst,
                                      output logic [31:0] imm);
        logic zext;
        zext = 1'b0; wr = 1'b0; rd = 1'b0; wm = 1'b0; dst = 5'd0;
        case (ins[31:26])
            6'h00:        begin wr = 1; dst = ins[15:11]; end
            6'h23:        begin wr = 1; rd = 1; dst = ins[20:16]; end
            6'h2B:        wm = 1;
            6'h08, 6'h0A: begin wr = 1; dst = ins[20:16]; end
            6'h0C, 6'h0D: begin wr = 1; dst = ins[20:16]; zext = 1; end
            default: ;
        endcase
        if (dst == 5'd0) wr = 1'b0;
        imm = zext ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    endfunction

    function automatic logic expHazard(input logic [31:0] ins);
        return mValid && mMemRd && mDst != 0 && (mDst == ins[25:21] || mDst == ins[20:16]);
    endfunction

    task automatic mClear();
        mValid = 0; mRegWr = 0; mMemRd = 0; mMemWr = 0;
        mOp = 0; mFunct = 0; mRs = 0; mRt = 0; mImm = 0; mDst = 0;
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] r, input logic [31:0] rf);
`ifdef ID_WB_BYPASS_EN
        if (bus.iWbRegWr && bus.iWbReg != 0 && bus.iWbReg == r) return bus.iWbData;
`endif
        return rf;
    endfunction

    always @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            mClear();
        end else begin
            logic rdy;
            rdy = (!mValid || bus.iExReady) && !expHazard(bus.iInstr);
            if (bus.iFlush) begin
                mClear();
            end else if (bus.iInstrValid && rdy) begin
                mValid = 1;
                mOp    = bus.iInstr[31:26];
                mFunct = bus.iInstr[5:0];
                mRs    = opnd(bus.iInstr[25:21], rfMem[bus.iInstr[25:21]]);
                mRt    = opnd(bus.iInstr[20:16], rfMem[bus.iInstr[20:16]]);
                refDecode(bus.iInstr, mRegWr, mMemRd, mMemWr, mDst, mImm);
            end else if (!mValid || bus.iExReady) begin
                mClear();
            end
        end
    end

    always @(negedge iClk) begin
        chk("exValid", {31'b0, bus.oExValid}, {31'b0, mValid});
        chk("exOp",    {26'b0, bus.oExOp},    {26'b0, mOp});
        chk("exFunct", {26'b0, bus.oExFunct}, {26'b0, mFunct});
        chk("exRs",    bus.oExRsData, mRs);
        chk("exRt",    bus.oExRtData, mRt);
        chk("exImm",   bus.oExImm,    mImm);
        chk("exDst",   {27'b0, bus.oExDstReg}, {27'b0, mDst});
        chk("exCtrl",  {29'b0, bus.oExRegWr, bus.oExMemRd, bus.oExMemWr},
                       {29'b0, mRegWr, mMemRd, mMemWr});
        chk("ready",   {31'b0, bus.oInstrReady},
                       {31'b0, (!mValid || bus.iExReady) && !expHazard(bus.iInstr)});
        chk("rfReg1",  {27'b0, bus.oRfReg1}, {27'b0, bus.iInstr[25:21]});
        chk("rfReg2",  {27'b0, bus.oRfReg2}, {27'b0, bus.iInstr[20:16]});
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    logic [31:0] stream [12] = '{32'h2823FFFF, 32'h3025ABCD, 32'h10220003, 32'h08000010,
                                 32'hFC000000, 32'h20200001, 32'h8C260008, 32'hAC460000,
                                 32'h8C200000, 32'h00001020, 32'h00011820, 32'h3405FFFF};
    logic        rdyPat [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        for (int i = 0; i < 32; i++) rfMem[i] = 32'h1000 * i + i;
        rfMem[0] = 0;
        rfMem[1] = 32'd5;
        iReset_n        = 0;
        bus.iInstrValid = 1;
        bus.iInstr      = 32'h2022FFFF;
        bus.iWbRegWr    = 0;
        bus.iWbReg      = 0;
        bus.iWbData     = 0;
        bus.iFlush      = 0;
        bus.iExReady    = 1;

        // Reset holds the entry empty even with a valid instruction offered
        tick(); tick(); tick();
        chk("rst_valid", {31'b0, bus.oExValid}, 32'd0);
        chk("rst_imm",   bus.oExImm, 32'd0);
        chk("rst_ctrl",  {29'b0, bus.oExRegWr, bus.oExMemRd, bus.oExMemWr}, 32'd0);

        // addi $2,$1,-1 accepted on the first edge after reset release
        iReset_n = 1;
        tick();
        chk("addi_valid", {31'b0, bus.oExValid}, 32'd1);
        chk("addi_rs",    bus.oExRsData, 32'd5);
        chk("addi_imm",   bus.oExImm, 32'hFFFFFFFF);
        chk("addi_dst",   {27'b0, bus.oExDstReg}, 32'd2);
        chk("addi_regwr", {31'b0, bus.oExRegWr}, 32'd1);

        // lw $3,0($1) then add $4,$3,$3: one stall, one bubble
        bus.iInstr = 32'h8C230000;
        tick();
        bus.iInstr = 32'h00632020;
        #1;
        chk("lu_stall", {31'b0, bus.oInstrReady}, 32'd0);
        tick();
        chk("lu_bubble", {31'b0, bus.oExValid}, 32'd0);
        chk("lu_ready",  {31'b0, bus.oInstrReady}, 32'd1);
        tick();
        chk("lu_issue",  {31'b0, bus.oExValid}, 32'd1);
        chk("lu_dst",    {27'b0, bus.oExDstReg}, 32'd4);

        // EX backpressure for 3 cycles with ori $5,$0,0x8000 waiting
        bus.iInstr   = 32'h34058000;
        bus.iExReady = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_dst",   {27'b0, bus.oExDstReg}, 32'd4);
            chk("hold_ready", {31'b0, bus.oInstrReady}, 32'd0);
        end
        bus.iExReady = 1;
        #1;
        chk("hold_release", {31'b0, bus.oInstrReady}, 32'd1);
        tick();
        chk("ori_imm", bus.oExImm, 32'h00008000);
        chk("ori_dst", {27'b0, bus.oExDstReg}, 32'd5);

        // Flush wins over an offered sw
        bus.iInstr = 32'hAC220004;
        bus.iFlush = 1;
        tick();
        chk("flush_valid", {31'b0, bus.oExValid}, 32'd0);
        bus.iFlush      = 0;
        bus.iInstrValid = 0;
        tick();
        chk("flush_drop", {31'b0, bus.oExValid}, 32'd0);

        // Writeback collision on $1
        rfMem[1]        = 0;
        bus.iWbRegWr    = 1;
        bus.iWbReg      = 5'd1;
        bus.iWbData     = 32'h1234;
        bus.iInstrValid = 1;
        bus.iInstr      = 32'h2022FFFF;
        tick();
`ifdef ID_WB_BYPASS_EN
        chk("wb_bypass", bus.oExRsData, 32'h1234);
`else
        chk("wb_bypass", bus.oExRsData, 32'h0);
`endif
        bus.iWbRegWr = 0;
        rfMem[1]     = 32'd5;

        // Mixed opcodes under intermittent backpressure; the model checks every cycle
        for (int i = 0; i < 12; i++) begin
            bus.iInstr   = stream[i];
            bus.iExReady = rdyPat[i];
            tick();
        end

        // Reset asserted while an entry is frozen
        bus.iExReady = 0;
        bus.iInstr   = 32'h2022FFFF;
        tick(); tick();
        chk("pre_rst_valid", {31'b0, bus.oExValid}, 32'd1);
        iReset_n = 0;
        #1;
        chk("midrst_valid", {31'b0, bus.oExValid}, 32'd0);
        chk("midrst_rs",    bus.oExRsData, 32'd0);
        tick();
        iReset_n     = 1;
        bus.iExReady = 1;
        bus.iInstr   = 32'h34058000;
        tick();
        chk("post_rst_accept", {31'b0, bus.oExValid}, 32'd1);
        chk("post_rst_imm",    bus.oExImm, 32'h00008000);

        bus.iInstrValid = 0;
        tick(); tick();
        @(negedge iClk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
